rep_pixel_2x: RTL and testbench

REP_PIXEL_2X -- requirements
Module: rep_pixel_2x

---
 rtl/rep_pixel_2x_pkg.sv | 28 ++
 rtl/rep_pixel_2x_raster_counter.sv | 57 +++++
 rtl/rep_pixel_2x.sv | 90 +++++++++
 tb/tb_rep_pixel_2x.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rep_pixel_2x_pkg.sv
// Shared scaler package: default source geometry, bus widths,
// FSM encoding and the write-pipe bundle used by the 2x replicator.
package rep_pixel_2x_pkg;

  localparam int SRC_W_DEF = 160;
  localparam int SRC_H_DEF = 120;
  localparam int ADDR_W    = 19;
  localparam int PIX_W     = 8;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [PIX_W-1:0]  pix_t;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  typedef struct packed {
    logic  vld;
    addr_t addr;
  } wr_t;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rep_pixel_2x_raster_counter.sv
// Raster walker: x fastest, then y; wraps at W/H, flags the last pixel.
// Ports: clk, rst_n (async low), en_i advance, x_o/y_o position, last_o.
module raster_counter
  import rep_pixel_2x_pkg::*;
#(
  parameter int W  = 320,
  parameter int H  = 240,
  parameter int XW = cnt_w(W),
  parameter int YW = cnt_w(H)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en_i,
  output logic [XW-1:0] x_o,
  output logic [YW-1:0] y_o,
  output logic          last_o
);

  localparam logic [XW-1:0] X_MAX = XW'(W - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(H - 1);

  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic          x_last;
  logic          y_last;

  assign x_last = (x_q == X_MAX);
  assign y_last = (y_q == Y_MAX);

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (en_i) begin
      if (x_last) begin
        x_d = '0;
        y_d = y_last ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign x_o    = x_q;
  assign y_o    = y_q;
  assign last_o = x_last & y_last;

endmodule

// File: rtl/rep_pixel_2x.sv
// 2x nearest-neighbour replicator: walks the destination raster, reads
// the source ROM (1-cycle latency) and writes each pixel to RAM once.
// Ports: clk, reset (async low), rom_addr/rom_data, ram_wraddr/
// ram_data/ram_wren, done (frame complete, held until reset).
module rep_pixel_2x
  import rep_pixel_2x_pkg::*;
#(
  parameter int SRC_W = SRC_W_DEF,
  parameter int SRC_H = SRC_H_DEF
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [PIX_W-1:0]  rom_data,
  output logic [ADDR_W-1:0] ram_wraddr,
  output logic [PIX_W-1:0]  ram_data,
  output logic              ram_wren,
  output logic              done
);

  localparam int    DST_W   = 2 * SRC_W;
  localparam int    DST_H   = 2 * SRC_H;
  localparam int    XW      = cnt_w(DST_W);
  localparam int    YW      = cnt_w(DST_H);
  localparam addr_t SRC_W_A = addr_t'(SRC_W);
  localparam addr_t DST_W_A = addr_t'(DST_W);

  state_t        state_q, state_d;
  wr_t           wr_q, wr_d;
  logic [XW-1:0] dx;
  logic [YW-1:0] dy;
  logic          at_end;
  logic          walk_en;
  addr_t         src_addr;
  addr_t         dst_addr;

  raster_counter #(
    .W  (DST_W),
    .H  (DST_H),
    .XW (XW),
    .YW (YW)
  ) u_walk (
    .clk    (clk),
    .rst_n  (reset),
    .en_i   (walk_en),
    .x_o    (dx),
    .y_o    (dy),
    .last_o (at_end)
  );

  assign src_addr = addr_t'(dy >> 1) * SRC_W_A
                  + addr_t'(dx >> 1);
  assign dst_addr = addr_t'(dy) * DST_W_A
                  + addr_t'(dx);

  // The walker parks on the last pixel so rom_addr stays put afterwards.
  always_comb begin
    state_d  = state_q;
    walk_en  = 1'b0;
    wr_d     = wr_q;
    wr_d.vld = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        walk_en = !at_end;
        wr_d    = '{vld: 1'b1, addr: dst_addr};
        if (at_end) state_d = ST_FLUSH;
      end
      ST_FLUSH: state_d = ST_DONE;
      ST_DONE:  state_d = ST_DONE;
      default:  state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_RUN;
      wr_q    <= '0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
    end
  end

  assign rom_addr   = src_addr;
  assign ram_wren   = wr_q.vld;
  assign ram_wraddr = wr_q.addr;
  assign ram_data   = wr_q.vld ? rom_data : '0;
  assign done       = (state_q == ST_DONE);

endmodule

// File: tb/tb_rep_pixel_2x.sv
// Self-checking bench for rep_pixel_2x with a 1-cycle ROM model.
// Reference: destination pixel value derived from raster arithmetic.
module tb_rep_pixel_2x;

  localparam int SW = 160;
  localparam int SH = 120;
  localparam int DW = 2 * SW;
  localparam int DH = 2 * SH;
  localparam int NPIX = DW * DH;

  logic        clk;
  logic        reset;
  logic [18:0] rom_addr;
  logic [7:0]  rom_data;
  logic [18:0] ram_wraddr;
  logic [7:0]  ram_data;
  logic        ram_wren;
  logic        done;

  int errors;
  int checks;

  bit         seen [NPIX];
  logic [7:0] mem  [NPIX];

  rep_pixel_2x dut (
    .clk        (clk),
    .reset      (reset),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .ram_wraddr (ram_wraddr),
    .ram_data   (ram_data),
    .ram_wren   (ram_wren),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= rom_addr[7:0];

  function automatic logic [7:0] exp_pix(input int a);
    int dx, dy, s;
    dx = a % DW;
    dy = a / DW;
    s  = (dy / 2) * SW + dx / 2;
    return s[7:0];
  endfunction

  task automatic test_reset();
    int n;
    n = 10 + $urandom_range(0, 5);
    reset = 1'b0;
    repeat (n) begin
      @(negedge clk);
      checks++;
      if ({rom_addr, ram_wraddr, ram_data, ram_wren, done} !== '0) begin
        errors++;
        $display("FAIL reset_outputs: rom_addr=%0d wraddr=%0d data=%0h wren=%b done=%b, required all 0",
                 rom_addr, ram_wraddr, ram_data, ram_wren, done);
      end
    end
  endtask

  task automatic test_abort(input int n);
    int nwr, bad, cyc;
    nwr = 0; bad = 0; cyc = 0;
    reset = 1'b1;
    while (nwr < n && cyc < 20000) begin
      @(posedge clk); cyc++;
      @(negedge clk);
      if (ram_wren) begin
        if (int'(ram_wraddr) != nwr || ram_data !== exp_pix(nwr)) bad++;
        nwr++;
      end
    end
    checks++;
    if (nwr != n) begin
      errors++;
      $display("FAIL abort_reach: writes=%0d required %0d", nwr, n);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL abort_prefix: bad writes=%0d required 0", bad);
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({rom_addr, ram_wraddr, ram_data, ram_wren, done} !== '0) begin
      errors++;
      $display("FAIL abort_async: rom_addr=%0d wraddr=%0d data=%0h wren=%b done=%b, required all 0",
               rom_addr, ram_wraddr, ram_data, ram_wren, done);
    end
    repeat (3) begin
      @(negedge clk);
      checks++;
      if ({rom_addr, ram_wraddr, ram_data, ram_wren, done} !== '0) begin
        errors++;
        $display("FAIL abort_hold: rom_addr=%0d wraddr=%0d wren=%b done=%b, required all 0",
                 rom_addr, ram_wraddr, ram_wren, done);
      end
    end
  endtask

  task automatic test_frame();
    int cyc, nwr, a, first_c, last_c, done_c;
    int order_bad, range_bad, dup, data_bad, early_done;
    int wren_cnt, done_low, rom_moves;
    logic [18:0] rom_at_done;
    int         spot_a [10];
    logic [7:0] spot_v [10];
    spot_a = '{0, 1, 2, 3, 319, 320, 321, 640, 959, 76799};
    spot_v = '{8'h00, 8'h00, 8'h01, 8'h01, 8'h9F,
               8'h00, 8'h00, 8'hA0, 8'h3F, 8'hFF};
    for (int i = 0; i < NPIX; i++) begin
      seen[i] = 1'b0;
      mem[i]  = 8'hxx;
    end
    cyc = 0; nwr = 0; first_c = -1; last_c = -1; done_c = -1;
    order_bad = 0; range_bad = 0; dup = 0; data_bad = 0; early_done = 0;
    rom_at_done = '0;
    reset = 1'b1;
    while (done_c < 0 && cyc < 80000) begin
      @(posedge clk); cyc++;
      @(negedge clk);
      if (ram_wren) begin
        if (first_c < 0) first_c = cyc;
        last_c = cyc;
        a = int'(ram_wraddr);
        if (a != nwr) order_bad++;
        if (a < NPIX) begin
          if (seen[a]) dup++;
          seen[a] = 1'b1;
          mem[a]  = ram_data;
          if (ram_data !== exp_pix(a)) data_bad++;
        end else begin
          range_bad++;
        end
        if (done) early_done++;
        nwr++;
      end else if (done) begin
        done_c = cyc;
        rom_at_done = rom_addr;
      end
    end
    checks++;
    if (done_c < 0) begin
      errors++;
      $display("FAIL frame_timeout: done never rose within %0d cycles", cyc);
    end
    checks++;
    if (first_c != 1) begin
      errors++;
      $display("FAIL first_write: wren first high after edge %0d, required 1 (commit on edge 2)", first_c);
    end
    checks++;
    if (nwr != NPIX) begin
      errors++;
      $display("FAIL write_count: %0d required %0d", nwr, NPIX);
    end
    checks++;
    if (last_c != NPIX) begin
      errors++;
      $display("FAIL last_write_cycle: %0d required %0d", last_c, NPIX);
    end
    checks++;
    if (order_bad != 0 || range_bad != 0) begin
      errors++;
      $display("FAIL raster_order: out-of-order=%0d out-of-range=%0d required 0", order_bad, range_bad);
    end
    checks++;
    if (dup != 0) begin
      errors++;
      $display("FAIL duplicates: %0d required 0", dup);
    end
    checks++;
    if (data_bad != 0) begin
      errors++;
      $display("FAIL pixel_data: %0d wrong pixels required 0", data_bad);
    end
    checks++;
    if (early_done != 0) begin
      errors++;
      $display("FAIL done_early: done high on %0d write cycles required 0", early_done);
    end
    checks++;
    if (done_c != last_c + 1) begin
      errors++;
      $display("FAIL done_timing: done at cycle %0d required %0d", done_c, last_c + 1);
    end
    checks++;
    if (rom_at_done !== 19'd19199) begin
      errors++;
      $display("FAIL rom_addr_final: %0d required 19199", rom_at_done);
    end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (mem[spot_a[i]] !== spot_v[i]) begin
        errors++;
        $display("FAIL spot_addr_%0d: got %0h required %0h", spot_a[i], mem[spot_a[i]], spot_v[i]);
      end
    end
    wren_cnt = 0; done_low = 0; rom_moves = 0;
    repeat (1000) begin
      @(negedge clk);
      if (ram_wren !== 1'b0) wren_cnt++;
      if (done !== 1'b1) done_low++;
      if (rom_addr !== rom_at_done) rom_moves++;
    end
    checks++;
    if (wren_cnt != 0) begin
      errors++;
      $display("FAIL post_done_wren: %0d pulses required 0", wren_cnt);
    end
    checks++;
    if (done_low != 0) begin
      errors++;
      $display("FAIL post_done_hold: done low %0d cycles required 0", done_low);
    end
    checks++;
    if (rom_moves != 0) begin
      errors++;
      $display("FAIL post_done_rom: rom_addr moved %0d cycles required 0", rom_moves);
    end
  endtask

  task automatic test_reset_in_done();
    reset = 1'b0;
    #1;
    checks++;
    if ({rom_addr, ram_wraddr, ram_data, ram_wren, done} !== '0) begin
      errors++;
      $display("FAIL done_reset_async: rom_addr=%0d wraddr=%0d wren=%b done=%b, required all 0",
               rom_addr, ram_wraddr, ram_wren, done);
    end
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (ram_wren !== 1'b1 || int'(ram_wraddr) != k || ram_data !== exp_pix(k)) begin
        errors++;
        $display("FAIL restart_write_%0d: wren=%b addr=%0d data=%0h required 1/%0d/%0h",
                 k, ram_wren, ram_wraddr, ram_data, k, exp_pix(k));
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset  = 1'b0;
    test_reset();
    test_abort($urandom_range(500, 8000));
    test_frame();
    test_reset_in_done();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
